// File: rtl/fetch_pc_gen.sv
// Instruction-fetch front end: owns the fetch PC, issues single-outstanding word
// fetches and buffers returned words, tagged with their PC, in a small FIFO for decode.
module fetch_pc_gen #(
    parameter int          IADDR_SPACE_BITS = 32,
    parameter logic [31:0] RESET_ADDR       = 32'h0000_0000,
    parameter int          FIFO_DEPTH       = 2
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_pc_select,
    input  logic [IADDR_SPACE_BITS-1:1]   i_pc_target,
    output logic                          o_ibus_req,
    output logic [IADDR_SPACE_BITS-1:2]   o_ibus_addr,
    input  logic                          i_ibus_ack,
    input  logic [31:0]                   i_ibus_data,
    output logic                          o_inst_valid,
    output logic [31:0]                   o_inst_data,
    output logic [IADDR_SPACE_BITS-1:1]   o_inst_pc,
    input  logic                          i_inst_ready
);
    localparam int AW    = IADDR_SPACE_BITS;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DISCARD
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:1]     fetch_pc_q, fetch_pc_d;
    logic [AW-1:2]     req_addr_q, req_addr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [31:0]       mem_data [FIFO_DEPTH];
    logic [AW-1:1]     mem_pc   [FIFO_DEPTH];

    logic              inst_valid;
    logic              pop;
    logic              push;
    logic [AW-1:2]     word_inc;

    assign inst_valid = (count_q != '0) && !i_reset;
    assign pop        = inst_valid && i_inst_ready && !i_pc_select;
    assign word_inc   = fetch_pc_q[AW-1:2] + (AW-2)'(1);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        push       = 1'b0;

        if (i_pc_select) begin
            // Flush everything; an outstanding unacked fetch must still be drained.
            fetch_pc_d = i_pc_target;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            if (state_q != ST_IDLE && !i_ibus_ack) begin
                state_d = ST_DISCARD;
            end else begin
                state_d = ST_REQ;
            end
        end else begin
            push = (state_q == ST_REQ) && i_ibus_ack;
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                fetch_pc_d = {word_inc, 1'b0};
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);

            case (state_q)
                ST_IDLE: begin
                    if (count_d < DEPTH_CNT) begin
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (i_ibus_ack) begin
                        state_d = (count_d < DEPTH_CNT) ? ST_REQ : ST_IDLE;
                    end
                end
                ST_DISCARD: begin
                    if (i_ibus_ack) begin
                        state_d = ST_REQ;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // The stale address stays on the bus until its ack arrives.
        req_addr_d = (state_d == ST_DISCARD) ? req_addr_q : fetch_pc_d[AW-1:2];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= {RESET_ADDR[AW-1:2], 1'b0};
            req_addr_q <= RESET_ADDR[AW-1:2];
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (push && wr_ptr_q == PTR_W'(i)) begin
                mem_data[i] <= i_ibus_data;
                mem_pc[i]   <= fetch_pc_q;
            end
        end
    end

    assign o_ibus_req   = (state_q != ST_IDLE);
    assign o_ibus_addr  = req_addr_q;
    assign o_inst_valid = inst_valid;
    assign o_inst_data  = inst_valid ? mem_data[rd_ptr_q] : '0;
    assign o_inst_pc    = inst_valid ? mem_pc[rd_ptr_q] : '0;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed scenarios plus a randomized run checked against
// a stream-level model (each accepted instruction must follow the architectural PC sequence).
module tb_fetch_pc_gen;
    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_pc_select;
    logic [30:0] i_pc_target;
    logic        o_ibus_req;
    logic [29:0] o_ibus_addr;
    logic        i_ibus_ack;
    logic [31:0] i_ibus_data;
    logic        o_inst_valid;
    logic [31:0] o_inst_data;
    logic [30:0] o_inst_pc;
    logic        i_inst_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_pc_gen #(
        .IADDR_SPACE_BITS(32),
        .RESET_ADDR      (32'h0000_0100),
        .FIFO_DEPTH      (2)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_pc_select (i_pc_select),
        .i_pc_target (i_pc_target),
        .o_ibus_req  (o_ibus_req),
        .o_ibus_addr (o_ibus_addr),
        .i_ibus_ack  (i_ibus_ack),
        .i_ibus_data (i_ibus_data),
        .o_inst_valid(o_inst_valid),
        .o_inst_data (o_inst_data),
        .o_inst_pc   (o_inst_pc),
        .i_inst_ready(i_inst_ready)
    );

    // Memory contents as a pure function of the word address.
    function automatic logic [31:0] mem_word(input logic [29:0] a);
        logic [31:0] x;
        x = {2'b00, a} * 32'h9E37_79B1;
        return x ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [30:0] next_pc(input logic [30:0] p);
        logic [30:0] w;
        w = p >> 1;
        w = w + 31'd1;
        return w << 1;
    endfunction

    // Called at a negedge: drive one cycle of inputs and return at the next negedge.
    task automatic tick(input logic sel, input logic [30:0] tgt, input logic ack, input logic rdy);
        i_pc_select  = sel;
        i_pc_target  = tgt;
        i_ibus_ack   = ack;
        i_inst_ready = rdy;
        i_ibus_data  = ack ? mem_word(o_ibus_addr) : $urandom;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        i_reset = 1'b1; i_pc_select = 1'b0; i_ibus_ack = 1'b0; i_inst_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        i_reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_pc_select = 1'b0; i_ibus_ack = 1'b1; i_inst_ready = 1'b1;
        i_ibus_data = 32'hDEAD_BEEF;
        #1;
        checks++; if (o_inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid_during: got %b expected 0", o_inst_valid); end
        checks++; if (o_inst_data !== 32'h0) begin failures++; $display("FAIL reset_data_during: got %h expected 0", o_inst_data); end
        checks++; if (o_inst_pc !== 31'h0) begin failures++; $display("FAIL reset_pc_during: got %h expected 0", o_inst_pc); end
        @(posedge clk);
        @(negedge clk);
        i_reset = 1'b0;
        #1;
        checks++; if (o_inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid_after: got %b expected 0", o_inst_valid); end
        checks++; if (o_inst_pc !== 31'h0) begin failures++; $display("FAIL reset_pc_after: got %h expected 0", o_inst_pc); end
        checks++; if (o_ibus_req !== 1'b1) begin failures++; $display("FAIL reset_req: got %b expected 1", o_ibus_req); end
        checks++; if (o_ibus_addr !== 30'h40) begin failures++; $display("FAIL reset_addr: got %h expected 40", o_ibus_addr); end
        $display("test_reset done");
    endtask

    task automatic test_stream();
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            checks++; if (o_ibus_addr !== 30'(32'h40 + k)) begin failures++; $display("FAIL stream_addr[%0d]: got %h expected %h", k, o_ibus_addr, 32'h40 + k); end
            if (k == 0) begin
                checks++; if (o_inst_valid !== 1'b0) begin failures++; $display("FAIL stream_valid0: got %b expected 0", o_inst_valid); end
            end else begin
                checks++; if (o_inst_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d]: got %b expected 1", k, o_inst_valid); end
                checks++; if (o_inst_pc !== 31'(32'h80 + 2 * (k - 1))) begin failures++; $display("FAIL stream_pc[%0d]: got %h expected %h", k, o_inst_pc, 32'h80 + 2 * (k - 1)); end
                checks++; if (o_inst_data !== mem_word(30'(32'h40 + k - 1))) begin failures++; $display("FAIL stream_data[%0d]: got %h expected %h", k, o_inst_data, mem_word(30'(32'h40 + k - 1))); end
            end
            $display("stream cycle %0d addr=%h valid=%b pc=%h", k, o_ibus_addr, o_inst_valid, o_inst_pc);
            tick(1'b0, 31'h0, 1'b1, 1'b1);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        tick(1'b0, 31'h0, 1'b1, 1'b0);
        tick(1'b0, 31'h0, 1'b1, 1'b0);
        checks++; if (o_ibus_req !== 1'b0) begin failures++; $display("FAIL bp_full_req: got %b expected 0", o_ibus_req); end
        checks++; if (o_inst_pc !== 31'h80) begin failures++; $display("FAIL bp_head_pc: got %h expected 80", o_inst_pc); end
        tick(1'b0, 31'h0, 1'b1, 1'b0);
        checks++; if (o_ibus_req !== 1'b0) begin failures++; $display("FAIL bp_idle_hold: got %b expected 0", o_ibus_req); end
        tick(1'b0, 31'h0, 1'b1, 1'b1);
        checks++; if (o_ibus_req !== 1'b1) begin failures++; $display("FAIL bp_rereq: got %b expected 1", o_ibus_req); end
        checks++; if (o_ibus_addr !== 30'h42) begin failures++; $display("FAIL bp_rereq_addr: got %h expected 42", o_ibus_addr); end
        checks++; if (o_inst_pc !== 31'h82) begin failures++; $display("FAIL bp_pc_after_pop: got %h expected 82", o_inst_pc); end
        tick(1'b0, 31'h0, 1'b1, 1'b1);
        checks++; if (o_inst_pc !== 31'h84 || o_inst_data !== mem_word(30'h42)) begin failures++; $display("FAIL bp_next: got pc=%h data=%h expected pc=84 data=%h", o_inst_pc, o_inst_data, mem_word(30'h42)); end
        $display("backpressure done pc=%h", o_inst_pc);
    endtask

    task automatic test_redirect_full();
        apply_reset();
        tick(1'b0, 31'h0, 1'b1, 1'b0);
        tick(1'b0, 31'h0, 1'b1, 1'b0);
        tick(1'b1, 31'h103, 1'b1, 1'b1);
        checks++; if (o_inst_valid !== 1'b0) begin failures++; $display("FAIL rf_flush_valid: got %b expected 0", o_inst_valid); end
        checks++; if (o_ibus_req !== 1'b1 || o_ibus_addr !== 30'h81) begin failures++; $display("FAIL rf_addr: got req=%b addr=%h expected req=1 addr=81", o_ibus_req, o_ibus_addr); end
        tick(1'b0, 31'h0, 1'b1, 1'b1);
        checks++; if ({o_inst_pc, 1'b0} !== 32'h206) begin failures++; $display("FAIL rf_first_pc: got %h expected 206", {o_inst_pc, 1'b0}); end
        checks++; if (o_inst_data !== mem_word(30'h81)) begin failures++; $display("FAIL rf_first_data: got %h expected %h", o_inst_data, mem_word(30'h81)); end
        tick(1'b0, 31'h0, 1'b1, 1'b1);
        checks++; if ({o_inst_pc, 1'b0} !== 32'h208) begin failures++; $display("FAIL rf_second_pc: got %h expected 208", {o_inst_pc, 1'b0}); end
        $display("redirect_full done pc=%h", o_inst_pc);
    endtask

    task automatic test_redirect_discard();
        apply_reset();
        tick(1'b1, 31'h200, 1'b0, 1'b1);
        checks++; if (o_ibus_req !== 1'b1 || o_ibus_addr !== 30'h40) begin failures++; $display("FAIL rd_stale1: got req=%b addr=%h expected req=1 addr=40", o_ibus_req, o_ibus_addr); end
        tick(1'b1, 31'h301, 1'b0, 1'b1);
        checks++; if (o_ibus_addr !== 30'h40) begin failures++; $display("FAIL rd_stale2: got %h expected 40", o_ibus_addr); end
        tick(1'b0, 31'h0, 1'b0, 1'b1);
        checks++; if (o_ibus_addr !== 30'h40) begin failures++; $display("FAIL rd_stale3: got %h expected 40", o_ibus_addr); end
        tick(1'b0, 31'h0, 1'b1, 1'b1);
        checks++; if (o_inst_valid !== 1'b0) begin failures++; $display("FAIL rd_dropped: got %b expected 0", o_inst_valid); end
        checks++; if (o_ibus_addr !== 30'h180) begin failures++; $display("FAIL rd_target_addr: got %h expected 180", o_ibus_addr); end
        tick(1'b0, 31'h0, 1'b1, 1'b1);
        checks++; if (o_inst_pc !== 31'h301 || o_inst_data !== mem_word(30'h180)) begin failures++; $display("FAIL rd_first: got pc=%h data=%h expected pc=301 data=%h", o_inst_pc, o_inst_data, mem_word(30'h180)); end
        tick(1'b0, 31'h0, 1'b1, 1'b1);
        checks++; if (o_inst_pc !== 31'h302) begin failures++; $display("FAIL rd_second_pc: got %h expected 302", o_inst_pc); end
        $display("redirect_discard done pc=%h", o_inst_pc);
    endtask

    task automatic test_redirect_ack_pop();
        apply_reset();
        tick(1'b0, 31'h0, 1'b1, 1'b1);
        tick(1'b1, 31'h2A0, 1'b1, 1'b1);
        checks++; if (o_inst_valid !== 1'b0) begin failures++; $display("FAIL rap_valid: got %b expected 0", o_inst_valid); end
        checks++; if (o_ibus_req !== 1'b1 || o_ibus_addr !== 30'h150) begin failures++; $display("FAIL rap_addr: got req=%b addr=%h expected req=1 addr=150", o_ibus_req, o_ibus_addr); end
        tick(1'b0, 31'h0, 1'b0, 1'b1);
        checks++; if (o_inst_valid !== 1'b0) begin failures++; $display("FAIL rap_empty: got %b expected 0", o_inst_valid); end
        tick(1'b0, 31'h0, 1'b1, 1'b1);
        checks++; if (o_inst_pc !== 31'h2A0 || o_inst_data !== mem_word(30'h150)) begin failures++; $display("FAIL rap_first: got pc=%h data=%h expected pc=2a0 data=%h", o_inst_pc, o_inst_data, mem_word(30'h150)); end
        $display("redirect_ack_pop done pc=%h", o_inst_pc);
    endtask

    task automatic test_wrap();
        apply_reset();
        tick(1'b1, 31'h7FFF_FFFE, 1'b1, 1'b1);
        checks++; if (o_ibus_addr !== 30'h3FFF_FFFF) begin failures++; $display("FAIL wrap_top_addr: got %h expected 3fffffff", o_ibus_addr); end
        tick(1'b0, 31'h0, 1'b1, 1'b1);
        checks++; if (o_ibus_addr !== 30'h0) begin failures++; $display("FAIL wrap_addr: got %h expected 0", o_ibus_addr); end
        checks++; if (o_inst_pc !== 31'h7FFF_FFFE || o_inst_data !== mem_word(30'h3FFF_FFFF)) begin failures++; $display("FAIL wrap_top_inst: got pc=%h data=%h", o_inst_pc, o_inst_data); end
        tick(1'b0, 31'h0, 1'b1, 1'b1);
        checks++; if (o_inst_pc !== 31'h0 || o_inst_data !== mem_word(30'h0)) begin failures++; $display("FAIL wrap_zero_inst: got pc=%h data=%h expected pc=0", o_inst_pc, o_inst_data); end
        $display("wrap done pc=%h", o_inst_pc);
    endtask

    task automatic test_random();
        logic [30:0] exp_pc;
        logic        prev_req, prev_ack, prev_sel;
        logic [29:0] prev_addr;
        logic        sel, ack, rdy;
        logic [30:0] tgt;
        int          accepted;
        apply_reset();
        exp_pc = 31'h80; accepted = 0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_sel = 1'b0; prev_addr = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            sel = ($urandom_range(15) == 0);
            tgt = 31'($urandom);
            ack = 1'($urandom_range(1));
            rdy = ($urandom_range(3) != 0);
            if (prev_req && !prev_ack) begin
                checks++; if (o_ibus_req !== 1'b1 || o_ibus_addr !== prev_addr) begin failures++; $display("FAIL rnd_addr_stable cyc=%0d: got req=%b addr=%h expected req=1 addr=%h", cyc, o_ibus_req, o_ibus_addr, prev_addr); end
            end
            if (prev_sel) begin
                checks++; if (o_inst_valid !== 1'b0) begin failures++; $display("FAIL rnd_flush cyc=%0d: got valid=%b expected 0", cyc, o_inst_valid); end
            end
            if (o_inst_valid && rdy && !sel) begin
                checks++;
                if (o_inst_pc !== exp_pc || o_inst_data !== mem_word(exp_pc[30:1])) begin
                    failures++;
                    $display("FAIL rnd_inst cyc=%0d: got pc=%h data=%h expected pc=%h data=%h", cyc, o_inst_pc, o_inst_data, exp_pc, mem_word(exp_pc[30:1]));
                end
                exp_pc = next_pc(exp_pc);
                accepted++;
            end
            if (sel) exp_pc = tgt;
            prev_req = o_ibus_req; prev_ack = ack; prev_sel = sel; prev_addr = o_ibus_addr;
            tick(sel, tgt, ack, rdy);
        end
        checks++; if (accepted < 300) begin failures++; $display("FAIL rnd_throughput: got %0d accepted expected >= 300", accepted); end
        $display("random done accepted=%0d", accepted);
    endtask

    initial begin
        i_reset = 1'b1; i_pc_select = 1'b0; i_pc_target = '0;
        i_ibus_ack = 1'b0; i_ibus_data = '0; i_inst_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_redirect_discard();
        test_redirect_ack_pop();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
